// File: rtl/segre_mp_register_file.sv
`default_nettype none
// ============================================================================
// Module   : segre_mp_register_file
// Purpose  : Multi-port integer register file with a per-register busy
//            scoreboard. x0 is hardwired to zero. Write ports resolve
//            same-address collisions in favour of the highest port index.
//            Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module segre_mp_register_file #(
  parameter int NUM_REGS  = 32,
  parameter int WORD_SIZE = 32,
  parameter int NR_READ   = 2,
  parameter int NR_WRITE  = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NR_READ-1:0][ADDR_W-1:0]      raddr_i,
  output logic [NR_READ-1:0][WORD_SIZE-1:0]   rdata_o,
  output logic [NR_READ-1:0]                  rready_o,
  input  logic [NR_WRITE-1:0]                 we_i,
  input  logic [NR_WRITE-1:0][ADDR_W-1:0]     waddr_i,
  input  logic [NR_WRITE-1:0][WORD_SIZE-1:0]  wdata_i,
  input  logic                                alloc_i,
  input  logic [ADDR_W-1:0]                   alloc_addr_i,
  input  logic                                flush_i,
  output logic [NUM_REGS-1:0]                 busy_o
);

  // Flat views of the storage and scoreboard, indexed by register number.
  // Entry 0 is tied to constants so x0 never needs storage.
  logic [WORD_SIZE-1:0] rf_view [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_view;

  assign rf_view[0]   = '0;
  assign busy_view[0] = 1'b0;
  assign busy_o       = busy_view;

  // --------------------------------------------------------------------------
  // One storage word plus one busy bit per architectural register x1..xN-1
  // --------------------------------------------------------------------------
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 wr_hit;

    // Write-port select: ports scanned low to high so the last match wins
    always_comb begin
      wr_hit = 1'b0;
      data_d = data_q;
      for (int p = 0; p < NR_WRITE; p++) begin
        if (we_i[p] && (waddr_i[p] == ADDR_W'(r))) begin
          wr_hit = 1'b1;
          data_d = wdata_i[p];
        end
      end
    end

    // Busy next state: flush beats alloc, alloc beats a same-cycle writeback
    always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
        busy_d = 1'b0;
      end else if (alloc_i && (alloc_addr_i == ADDR_W'(r))) begin
        busy_d = 1'b1;
      end else if (wr_hit) begin
        busy_d = 1'b0;
      end
    end

    // Storage and scoreboard state, cleared asynchronously by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign rf_view[r]   = data_q;
    assign busy_view[r] = busy_q;
  end

  // --------------------------------------------------------------------------
  // Combinational read ports
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NR_READ; k++) begin : g_read
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_ready;

    // Stored value and readiness, optionally overridden by an in-flight write
    always_comb begin
      rd_data  = rf_view[raddr_i[k]];
      rd_ready = ~busy_view[raddr_i[k]];
`ifdef RF_BYPASS_EN
      // Forwarding is suppressed in reset so outputs read as cleared state
      for (int p = 0; p < NR_WRITE; p++) begin
        if (!rst_i && we_i[p] && (raddr_i[k] != '0) && (waddr_i[p] == raddr_i[k])) begin
          rd_data  = wdata_i[p];
          rd_ready = 1'b1;
        end
      end
`endif
    end

    assign rdata_o[k]  = rd_data;
    assign rready_o[k] = rd_ready;
  end

endmodule
`default_nettype wire

// File: tb/tb_segre_mp_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_segre_mp_register_file
// Purpose  : Directed self-checking bench for segre_mp_register_file with two
//            read and two write ports. Expected results are queued when the
//            stimulus is applied and drained against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segre_mp_register_file;

  localparam int NUM_REGS  = 32;
  localparam int WORD_SIZE = 32;
  localparam int NR_READ   = 2;
  localparam int NR_WRITE  = 2;
  localparam int ADDR_W    = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                               clk_i = 1'b0;
  logic                               rst_i;
  logic [NR_READ-1:0][ADDR_W-1:0]     raddr_i;
  logic [NR_READ-1:0][WORD_SIZE-1:0]  rdata_o;
  logic [NR_READ-1:0]                 rready_o;
  logic [NR_WRITE-1:0]                we_i;
  logic [NR_WRITE-1:0][ADDR_W-1:0]    waddr_i;
  logic [NR_WRITE-1:0][WORD_SIZE-1:0] wdata_i;
  logic                               alloc_i;
  logic [ADDR_W-1:0]                  alloc_addr_i;
  logic                               flush_i;
  logic [NUM_REGS-1:0]                busy_o;

  segre_mp_register_file #(
    .NUM_REGS (NUM_REGS),
    .WORD_SIZE(WORD_SIZE),
    .NR_READ  (NR_READ),
    .NR_WRITE (NR_WRITE)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .raddr_i     (raddr_i),
    .rdata_o     (rdata_o),
    .rready_o    (rready_o),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .alloc_i     (alloc_i),
    .alloc_addr_i(alloc_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = rdata_o[idx], 1 = rready_o[idx], 2 = busy_o
  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic idle();
    we_i    = '0;
    waddr_i = '0;
    wdata_i = '0;
    alloc_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic expect_rd(input string tag, input int k, input logic [31:0] d, input logic rdy);
    push({tag, "_data"}, 0, k, d);
    push({tag, "_rdy"}, 1, k, {31'b0, rdy});
  endtask

  task automatic expect_busy(input string tag, input logic [31:0] b);
    push({tag, "_busy"}, 2, 0, b);
  endtask

  // Let combinational outputs settle, then drain the scoreboard
  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       obs = rdata_o[e.idx];
        1:       obs = {31'b0, rready_o[e.idx]};
        default: obs = busy_o;
      endcase
      n_total++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a write attempted while reset is held
    rst_i        = 1'b1;
    idle();
    alloc_addr_i = '0;
    raddr_i[0]   = 5'd5;
    raddr_i[1]   = 5'd0;
    we_i[0]      = 1'b1;
    waddr_i[0]   = 5'd5;
    wdata_i[0]   = 32'hCAFE_F00D;
    expect_rd("rst_p0", 0, 32'h0, 1'b1);
    expect_rd("rst_p1", 1, 32'h0, 1'b1);
    expect_busy("rst", 32'h0);
    check();
    tick();
    rst_i = 1'b0;
    idle();

    // x0: write and alloc must both be dropped
    we_i[0]      = 1'b1;
    waddr_i[0]   = 5'd0;
    wdata_i[0]   = 32'hFFFF_FFFF;
    alloc_i      = 1'b1;
    alloc_addr_i = 5'd0;
    tick();
    idle();
    raddr_i[0] = 5'd0;
    raddr_i[1] = 5'd5;
    expect_rd("x0", 0, 32'h0, 1'b1);
    expect_rd("x5_after_rst", 1, 32'h0, 1'b1);
    expect_busy("x0", 32'h0);
    check();

    // Both write ports target x7: port 1 wins
    we_i       = 2'b11;
    waddr_i[0] = 5'd7;
    waddr_i[1] = 5'd7;
    wdata_i[0] = 32'h11;
    wdata_i[1] = 32'h22;
    raddr_i[1] = 5'd7;
    expect_rd("prio_same", 1, BYP ? 32'h22 : 32'h0, 1'b1);
    check();
    tick();
    idle();
    expect_rd("prio", 1, 32'h22, 1'b1);
    check();

    // Allocate x3, wait a cycle, write it back
    alloc_i      = 1'b1;
    alloc_addr_i = 5'd3;
    raddr_i[0]   = 5'd3;
    expect_rd("alloc_same", 0, 32'h0, 1'b1);
    check();
    tick();
    idle();
    expect_rd("alloc", 0, 32'h0, 1'b0);
    expect_busy("alloc", 32'h1 << 3);
    check();
    tick();
    we_i[0]    = 1'b1;
    waddr_i[0] = 5'd3;
    wdata_i[0] = 32'hAB;
    expect_rd("wb_same", 0, BYP ? 32'hAB : 32'h0, BYP);
    expect_busy("wb_same", 32'h1 << 3);
    check();
    tick();
    idle();
    expect_rd("wb", 0, 32'hAB, 1'b1);
    expect_busy("wb", 32'h0);
    check();

    // Alloc and write x4 in the same cycle: data lands, busy stays set
    alloc_i      = 1'b1;
    alloc_addr_i = 5'd4;
    we_i[1]      = 1'b1;
    waddr_i[1]   = 5'd4;
    wdata_i[1]   = 32'h5;
    tick();
    idle();
    raddr_i[0] = 5'd4;
    expect_rd("aw", 0, 32'h5, 1'b0);
    expect_busy("aw", 32'h1 << 4);
    check();

    // Flush with a same-cycle alloc of x6: everything clears
    flush_i      = 1'b1;
    alloc_i      = 1'b1;
    alloc_addr_i = 5'd6;
    tick();
    idle();
    expect_rd("flush", 0, 32'h5, 1'b1);
    expect_busy("flush", 32'h0);
    check();

    // Write x9 while reading it
    raddr_i[1] = 5'd9;
    we_i[0]    = 1'b1;
    waddr_i[0] = 5'd9;
    wdata_i[0] = 32'h1234;
    expect_rd("byp_same", 1, BYP ? 32'h1234 : 32'h0, 1'b1);
    check();
    tick();
    idle();
    expect_rd("byp_next", 1, 32'h1234, 1'b1);
    check();

    // Load x5 and busy x10, then assert reset mid-cycle
    we_i[0]      = 1'b1;
    waddr_i[0]   = 5'd5;
    wdata_i[0]   = 32'hDEAD;
    alloc_i      = 1'b1;
    alloc_addr_i = 5'd10;
    tick();
    idle();
    raddr_i[0] = 5'd5;
    expect_rd("x5", 0, 32'hDEAD, 1'b1);
    expect_busy("x5", 32'h1 << 10);
    check();
    #1;
    rst_i      = 1'b1;
    we_i[0]    = 1'b1;
    waddr_i[0] = 5'd5;
    wdata_i[0] = 32'hBEEF;
    alloc_i    = 1'b1;
    expect_rd("midrst_p0", 0, 32'h0, 1'b1);
    expect_rd("midrst_p1", 1, 32'h0, 1'b1);
    expect_busy("midrst", 32'h0);
    check();
    tick();
    rst_i = 1'b0;
    idle();
    expect_rd("post_rst_p0", 0, 32'h0, 1'b1);
    expect_busy("post_rst", 32'h0);
    check();

    // Single-port write from port 0 with port 1 idle
    we_i[0]    = 1'b1;
    waddr_i[0] = 5'd31;
    wdata_i[0] = 32'hA5A5_5A5A;
    waddr_i[1] = 5'd31;
    wdata_i[1] = 32'h0BAD_0BAD;
    tick();
    idle();
    raddr_i[1] = 5'd31;
    expect_rd("x31", 1, 32'hA5A5_5A5A, 1'b1);
    check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
